// File: rtl/dtw_ref_dbuf.sv
// dtw_ref_dbuf: double-buffered DTW reference memory.
// The shadow bank loads from a FWFT FIFO while the active bank serves reads.
module dtw_ref_dbuf #(
  parameter int DATA_WIDTH       = 16,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int NUM_RD_PORTS     = 2,
  parameter int REF_INIT         = 0
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   rs_in,
  input  logic                                   op_mode_in,
  input  logic [REFMEM_PTR_WIDTH-1:0]            ref_len_in,
  input  logic                                   swap_req_in,
  output logic                                   busy_out,
  output logic                                   load_done_out,
  output logic                                   shadow_valid_out,
  output logic                                   active_bank_out,
  output logic                                   src_fifo_clear_out,
  output logic                                   src_fifo_rden_out,
  input  logic                                   src_fifo_empty_in,
  input  logic [DATA_WIDTH-1:0]                  src_fifo_data_in,
  input  logic [NUM_RD_PORTS*REFMEM_PTR_WIDTH-1:0] ref_rd_addr_in,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     ref_rd_data_out,
  output logic [1:0]                             dbg_state,
  output logic [REFMEM_PTR_WIDTH-1:0]            dbg_wr_addr
);
  localparam int AW    = REFMEM_PTR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic         shadow_q, shadow_d;
  logic         bank_q, bank_d;
  logic         done_q, done_d;
  logic [NUM_RD_PORTS*DW-1:0] rd_q, rd_d;

  logic load_go, last_wr, load_entry, fin, swap;

  assign load_go    = op_mode_in && (ref_len_in != '0);
  assign last_wr    = src_fifo_rden_out && (wr_addr_q == len_q - 1'b1);
  assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);
  assign fin        = (state_q == S_LOAD) && rs_in && last_wr;
  assign swap       = swap_req_in && shadow_q && (state_q != S_LOAD);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rs_in && load_go)          state_d = S_LOAD;
        else if (rs_in && !op_mode_in) state_d = S_READ;
      end
      S_READ: begin
        if (load_go)     state_d = S_LOAD;
        else if (!rs_in) state_d = S_IDLE;
      end
      S_LOAD: begin
        if (!rs_in)       state_d = S_IDLE;
        else if (last_wr) state_d = op_mode_in ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out           = (state_q != S_IDLE);
    src_fifo_clear_out = (state_q == S_IDLE);
    src_fifo_rden_out  = (state_q == S_LOAD) && !src_fifo_empty_in;
  end

  // An abort never reaches fin, so shadow_valid stays cleared from entry.
  always_comb begin
    len_d     = len_q;
    wr_addr_d = wr_addr_q;
    shadow_d  = shadow_q;
    bank_d    = bank_q;
    done_d    = 1'b0;
    if (swap) begin
      bank_d   = ~bank_q;
      shadow_d = 1'b0;
    end
    if (load_entry) begin
      len_d     = ref_len_in;
      wr_addr_d = '0;
      shadow_d  = 1'b0;
    end else if (src_fifo_rden_out) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end
    if (fin) begin
      shadow_d = 1'b1;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      len_q     <= '0;
      wr_addr_q <= '0;
      shadow_q  <= 1'b0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
    end else begin
      len_q     <= len_d;
      wr_addr_q <= wr_addr_d;
      shadow_q  <= shadow_d;
      bank_q    <= bank_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
    end
  end

  // Bank storage is never reset; REF_INIT only selects a zeroed power-up image.
  if (REF_INIT != 0) begin : g_mem
    logic [DW-1:0] mem_q [2][DEPTH] = '{default: '{default: '0}};
    always_ff @(posedge clk_in) begin
      if (src_fifo_rden_out) mem_q[~bank_q][wr_addr_q] <= src_fifo_data_in;
    end
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      assign rd_d[p*DW +: DW] = mem_q[bank_q][ref_rd_addr_in[p*AW +: AW]];
    end
  end else begin : g_mem
    logic [DW-1:0] mem_q [2][DEPTH];
    always_ff @(posedge clk_in) begin
      if (src_fifo_rden_out) mem_q[~bank_q][wr_addr_q] <= src_fifo_data_in;
    end
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      assign rd_d[p*DW +: DW] = mem_q[bank_q][ref_rd_addr_in[p*AW +: AW]];
    end
  end

  assign load_done_out    = done_q;
  assign shadow_valid_out = shadow_q;
  assign active_bank_out  = bank_q;
  assign ref_rd_data_out  = rd_q;
  assign dbg_state        = state_q;
  assign dbg_wr_addr      = wr_addr_q;
endmodule

// File: tb/tb_dtw_ref_dbuf.sv
// tb_dtw_ref_dbuf: directed bench for the double-buffered reference memory.
// A small FWFT FIFO model feeds the load path; two read ports observe banks.
module tb_dtw_ref_dbuf;
  logic        clk = 1'b0;
  logic        rst, rs, mode, swap;
  logic [3:0]  len;
  logic        busy, ld, sv, ab, clr, rden, empty;
  logic [15:0] fdata;
  logic [7:0]  addr;
  logic [31:0] rdata;
  logic [1:0]  dstate;
  logic [3:0]  dwa;

  logic [15:0] fmem [64];
  int fcnt = 0;
  int fidx = 0;
  int lcnt = 0;
  int tests = 0;
  int fails = 0;

  dtw_ref_dbuf #(
    .DATA_WIDTH(16), .REFMEM_PTR_WIDTH(4),
    .NUM_RD_PORTS(2), .REF_INIT(1)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rs_in(rs),
    .op_mode_in(mode), .ref_len_in(len), .swap_req_in(swap),
    .busy_out(busy), .load_done_out(ld),
    .shadow_valid_out(sv), .active_bank_out(ab),
    .src_fifo_clear_out(clr), .src_fifo_rden_out(rden),
    .src_fifo_empty_in(empty), .src_fifo_data_in(fdata),
    .ref_rd_addr_in(addr), .ref_rd_data_out(rdata),
    .dbg_state(dstate), .dbg_wr_addr(dwa)
  );

  always #5 clk = ~clk;

  assign empty = (fidx >= fcnt);
  assign fdata = fmem[fidx];

  always @(posedge clk) begin
    if (rden) fidx <= fidx + 1;
    if (ld)   lcnt <= lcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    fmem[fcnt] = v;
    fcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests++; if (dstate !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", dstate); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (clr !== 1'b1) begin fails++; $display("FAIL rst_clear: got %b want 1", clr); end
    tests++; if ({sv, ab, ld} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {sv, ab, ld}); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    tests++; if (dwa !== 4'd0) begin fails++; $display("FAIL rst_wr_addr: got %0d want 0", dwa); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    int f0, l0;
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC); push(16'hDDDD);
    f0 = fidx; l0 = lcnt;
    rs = 1'b1; mode = 1'b1; len = 4'd4;
    step();
    tests++; if (dstate !== 2'd1) begin fails++; $display("FAIL load_entry: state %0d want 1", dstate); end
    tests++; if ({clr, rden} !== 2'b01) begin fails++; $display("FAIL load_strobes: clr,rden %b want 01", {clr, rden}); end
    mode = 1'b0;
    len = 4'd9;
    for (int i = 0; i < 10 && !ld; i++) step();
    tests++; if (ld !== 1'b1) begin fails++; $display("FAIL load_done: got %b want 1", ld); end
    tests++; if (fidx - f0 != 4) begin fails++; $display("FAIL load_rden: got %0d want 4", fidx - f0); end
    tests++; if ({sv, ab} !== 2'b10) begin fails++; $display("FAIL load_bank: sv,ab %b want 10", {sv, ab}); end
    tests++; if (dstate !== 2'd2) begin fails++; $display("FAIL load_exit: state %0d want 2", dstate); end
    step();
    tests++; if (ld !== 1'b0) begin fails++; $display("FAIL load_pulse: got %b want 0", ld); end
    tests++; if (lcnt - l0 != 1) begin fails++; $display("FAIL load_pulses: got %0d want 1", lcnt - l0); end
  endtask

  task automatic test_swap();
    addr = {4'd0, 4'd2};
    swap = 1'b1;
    step();
    swap = 1'b0;
    tests++; if ({ab, sv} !== 2'b10) begin fails++; $display("FAIL swap_bank: ab,sv %b want 10", {ab, sv}); end
    tests++; if (rdata[15:0] !== 16'h0) begin fails++; $display("FAIL swap_oldbank: got %h want 0", rdata[15:0]); end
    step();
    tests++; if (rdata[15:0] !== 16'hCCCC) begin fails++; $display("FAIL swap_p0: got %h want cccc", rdata[15:0]); end
    tests++; if (rdata[31:16] !== 16'hAAAA) begin fails++; $display("FAIL swap_p1: got %h want aaaa", rdata[31:16]); end
  endtask

  task automatic test_concurrent();
    push(16'hEEEE); push(16'hFFFF); push(16'h1111); push(16'h2222);
    mode = 1'b1; len = 4'd4; swap = 1'b1;
    step();
    mode = 1'b0;
    for (int i = 0; i < 10 && !ld; i++) begin
      tests++; if (rdata !== 32'hAAAA_CCCC) begin fails++; $display("FAIL conc_rdata: got %h want aaaacccc", rdata); end
      tests++; if (ab !== 1'b1) begin fails++; $display("FAIL conc_bank: got %b want 1", ab); end
      step();
    end
    swap = 1'b0;
    tests++; if (ld !== 1'b1) begin fails++; $display("FAIL conc_done: got %b want 1", ld); end
    tests++; if ({ab, sv} !== 2'b11) begin fails++; $display("FAIL conc_flags: ab,sv %b want 11", {ab, sv}); end
    swap = 1'b1;
    step();
    swap = 1'b0;
    step();
    tests++; if (rdata !== 32'hEEEE_1111) begin fails++; $display("FAIL conc_newbank: got %h want eeee1111", rdata); end
    tests++; if (ab !== 1'b0) begin fails++; $display("FAIL conc_swap: got %b want 0", ab); end
  endtask

  task automatic test_stall_abort();
    int f0, l0;
    push(16'h0101); push(16'h0202); push(16'h0303);
    f0 = fidx; l0 = lcnt;
    mode = 1'b1; len = 4'd8;
    step();
    mode = 1'b0;
    repeat (6) step();
    tests++; if (fidx - f0 != 3) begin fails++; $display("FAIL stall_rden: got %0d want 3", fidx - f0); end
    tests++; if (dwa !== 4'd3) begin fails++; $display("FAIL stall_wr_addr: got %0d want 3", dwa); end
    tests++; if ({dstate, rden} !== 3'b010) begin fails++; $display("FAIL stall_hold: state,rden %b want 010", {dstate, rden}); end
    rs = 1'b0;
    step();
    tests++; if ({dstate, sv} !== 3'b000) begin fails++; $display("FAIL abort_state: state,sv %b want 000", {dstate, sv}); end
    tests++; if (lcnt != l0) begin fails++; $display("FAIL abort_done: pulses %0d want 0", lcnt - l0); end
    push(16'h0A0A); push(16'h0B0B);
    rs = 1'b1; mode = 1'b1; len = 4'd2;
    step();
    mode = 1'b0;
    tests++; if (dwa !== 4'd0) begin fails++; $display("FAIL restart_addr: got %0d want 0", dwa); end
    step();
    tests++; if (dwa !== 4'd1) begin fails++; $display("FAIL restart_incr: got %0d want 1", dwa); end
    step();
    tests++; if ({ld, dstate} !== 3'b110) begin fails++; $display("FAIL restart_done: ld,state %b want 110", {ld, dstate}); end
    addr = {4'd2, 4'd0};
    swap = 1'b1;
    step();
    swap = 1'b0;
    step();
    tests++; if (rdata !== 32'h0303_0A0A) begin fails++; $display("FAIL restart_data: got %h want 03030a0a", rdata); end
  endtask

  task automatic test_edge();
    rs = 1'b0;
    step();
    rs = 1'b1; mode = 1'b1; len = 4'd0;
    step();
    tests++; if ({dstate, busy} !== 3'b000) begin fails++; $display("FAIL zero_len: state,busy %b want 000", {dstate, busy}); end
    push(16'h5555);
    len = 4'd4;
    step();
    step();
    tests++; if ({dstate, dwa} !== 6'b01_0001) begin fails++; $display("FAIL midload: state,wa %b want 010001", {dstate, dwa}); end
    rst = 1'b1;
    step();
    tests++; if ({dstate, dwa} !== 6'd0) begin fails++; $display("FAIL rst_mid_state: got %b want 0", {dstate, dwa}); end
    tests++; if ({sv, ab, ld, busy} !== 4'b0000) begin fails++; $display("FAIL rst_mid_flags: got %b want 0000", {sv, ab, ld, busy}); end
    tests++; if ({clr, rden} !== 2'b10) begin fails++; $display("FAIL rst_mid_fifo: clr,rden %b want 10", {clr, rden}); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
    rst = 1'b0; rs = 1'b0; mode = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; rs = 1'b0; mode = 1'b0; swap = 1'b0;
    len = 4'd0; addr = 8'd0;
    test_reset();
    test_load();
    test_swap();
    test_concurrent();
    test_stall_abort();
    test_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dtw_ref_dbuf.md
DTW_REF_DBUF -- requirements
Module: dtw_ref_dbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, reference sample width in bits.
REQ-002 SHALL have parameter REFMEM_PTR_WIDTH, default 20, address width; each bank holds 2^REFMEM_PTR_WIDTH words.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, number of independent read ports (range 1..8).
REQ-004 SHALL have parameter REF_INIT, default 0; 1 = both banks zero-initialised at time 0.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk_in  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_in  in  1  synchronous active-high reset.
REQ-008 rs_in  in  1  run (1) / stop (0).
REQ-009 op_mode_in  in  1  0 = DTW_READ, 1 = LOAD_REF.
REQ-010 ref_len_in  in  REFMEM_PTR_WIDTH  words to load; sampled on LOAD entry.
REQ-011 swap_req_in  in  1  request to exchange active and shadow banks.
REQ-012 busy_out  out  1  high when not IDLE.
REQ-013 load_done_out  out  1  one-cycle pulse when the shadow load completes.
REQ-014 shadow_valid_out  out  1  shadow bank holds a complete reference.
REQ-015 active_bank_out  out  1  index of the bank served to the read ports.
REQ-016 src_fifo_clear_out  out  1  source FIFO clear.
REQ-017 src_fifo_rden_out  out  1  source FIFO read strobe (FWFT FIFO).
REQ-018 src_fifo_empty_in  in  1  source FIFO empty.
REQ-019 src_fifo_data_in  in  DATA_WIDTH  FIFO head word; valid while not empty.
REQ-020 ref_rd_addr_in  in  NUM_RD_PORTS*REFMEM_PTR_WIDTH  flattened read addresses; port p at slice [p*W +: W].
REQ-021 ref_rd_data_out  out  NUM_RD_PORTS*DATA_WIDTH  flattened registered read data.
REQ-022 dbg_state  out  2  FSM state; dbg_wr_addr  out  REFMEM_PTR_WIDTH  shadow write pointer.

Function
REQ-023 FSM SHALL have states IDLE=0, LOAD=1, READ=2; encoding 3 is unused and SHALL return to IDLE.
REQ-024 IDLE: rs_in & op_mode_in=1 & ref_len_in!=0 -> LOAD; rs_in & op_mode_in=0 -> READ; otherwise stay in IDLE.
REQ-025 READ: op_mode_in=1 & ref_len_in!=0 -> LOAD; !rs_in -> IDLE.
REQ-026 LOAD: !rs_in -> IDLE (abort); after the final write -> READ if rs_in & op_mode_in=0, else IDLE.
REQ-027 On LOAD entry: latch ref_len_in into len_q, clear wr_addr to 0, clear shadow_valid (overwrite of a pending shadow is permitted).
REQ-028 src_fifo_rden_out SHALL equal (state==LOAD) & !src_fifo_empty_in, combinationally.
REQ-029 Each cycle with rden high: write src_fifo_data_in to shadow bank (!active_bank) at wr_addr, then increment wr_addr.
REQ-030 A write at wr_addr==len_q-1 is the final write; the next cycle sets shadow_valid=1, pulses load_done_out for exactly 1 cycle, and leaves LOAD.
REQ-031 FIFO empty mid-load SHALL stall the load with no write and no timeout.
REQ-032 An abort SHALL leave shadow_valid=0 and produce no load_done_out pulse.
REQ-033 src_fifo_clear_out SHALL equal (state==IDLE).
REQ-034 Swap: swap_req_in & shadow_valid & state!=LOAD toggles active_bank and clears shadow_valid at the next edge.
REQ-035 swap_req_in SHALL be ignored (not queued) in LOAD, when shadow_valid=0, and in the final-write cycle.
REQ-036 Read port p: ref_rd_data_out slice p <= active bank[addr p], 1-cycle latency, in every state including LOAD.
REQ-037 Reads sampled on a swap edge SHALL use the old bank; reads from the following cycle SHALL use the new bank.
REQ-038 Reads SHALL never observe shadow writes; no read/write collision exists.
REQ-039 ref_len_in changes after LOAD entry SHALL have no effect on the current load.

Reset
REQ-040 rst_in SHALL force state=IDLE, wr_addr=0, len_q=0, shadow_valid=0, active_bank=0, load_done_out=0, ref_rd_data_out=0.
REQ-041 Reset mid-LOAD SHALL discard the partial load; bank contents SHALL NOT be reset.

Verification
REQ-042 Load: len=4, FIFO supplies A,B,C,D with rs=1, mode=1 -> 4 rden cycles, load_done pulses once, shadow_valid=1, active_bank still 0.
REQ-043 Swap: after REQ-042, pulse swap_req in READ -> active_bank=1; port 0 addr 2 -> C after 1 cycle; port 1 addr 0 -> A.
REQ-044 Concurrent: load bank 0 while ports read bank 1 -> read data unchanged throughout; swap_req during LOAD is ignored.
REQ-045 Stall/abort: len=8, FIFO empties after 3 words, then rs=0 -> IDLE, shadow_valid=0, no load_done; restart writes from addr 0.
REQ-046 Edge cases: ref_len_in=0 with mode=1 -> stays IDLE; rst_in mid-load -> all outputs at reset values the next cycle.
